// File: rtl/mod_counter.sv
// Modulo-N up/down counter with enable-gated prescaler, synchronous clear and
// saturating parallel load. Single clock domain; tc is combinational, wrap registered.
module mod_counter #(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MODULO   = 16,
  parameter int unsigned     PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam int unsigned      PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_Q    = WIDTH'(MODULO - 1);
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]    pre;
  logic [PW-1:0]    pre_next;
  logic [WIDTH-1:0] q_next;
  logic             wrap_next;
  logic             tick;

  // With PRESCALE==1 the prescaler is pinned at 0, so tick reduces to en.
  assign tick = en && (pre == PRE_LAST);
  assign tc   = up ? (q == MAX_Q) : (q == '0);

  always_comb begin
    q_next    = q;
    pre_next  = pre;
    wrap_next = 1'b0;
    if (clear) begin
      q_next   = '0;
      pre_next = '0;
    end else if (load) begin
      q_next   = (load_val > MAX_Q) ? MAX_Q : load_val;
      pre_next = '0;
    end else if (en) begin
      pre_next = tick ? '0 : pre + PW'(1);
      if (tick) begin
        if (up) begin
          if (q == MAX_Q) begin
            q_next    = '0;
            wrap_next = 1'b1;
          end else begin
            q_next = q + WIDTH'(1);
          end
        end else begin
          if (q == '0) begin
            q_next    = MAX_Q;
            wrap_next = 1'b1;
          end else begin
            q_next = q - WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q    <= '0;
      pre  <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= q_next;
      pre  <= pre_next;
      wrap <= wrap_next;
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: MODULO=10 with PRESCALE 1 and 3 side by side, driven by
// directed steps then random stimulus, compared against an arithmetic reference model.
module tb_mod_counter;

  localparam int unsigned M = 10;

  logic       clk = 1'b0;
  logic       reset, en, up, clear, load;
  logic [3:0] load_val;
  logic [3:0] q_a, q_b;
  logic       tc_a, tc_b, wrap_a, wrap_b;

  int unsigned presc[2] = '{1, 3};
  int unsigned mq[2];
  int unsigned mpre[2];
  logic        mwrap[2];
  int          total  = 0;
  int          passed = 0;

  mod_counter #(.WIDTH(4), .MODULO(10), .PRESCALE(1)) dut_a (
    .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .q(q_a), .tc(tc_a), .wrap(wrap_a)
  );

  mod_counter #(.WIDTH(4), .MODULO(10), .PRESCALE(3)) dut_b (
    .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .q(q_b), .tc(tc_b), .wrap(wrap_b)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i] = 0; mpre[i] = 0; mwrap[i] = 1'b0;
    end
  endtask

  // Reference: count value as an integer modulo M, prescaler as a phase counter.
  task automatic model_edge();
    if (!reset) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        mwrap[i] = 1'b0;
        if (clear) begin
          mq[i] = 0; mpre[i] = 0;
        end else if (load) begin
          mq[i] = (int'(load_val) > M - 1) ? M - 1 : int'(load_val);
          mpre[i] = 0;
        end else if (en) begin
          if (mpre[i] == presc[i] - 1) begin
            mpre[i] = 0;
            if (up) begin
              mwrap[i] = (mq[i] == M - 1);
              mq[i] = (mq[i] + 1) % M;
            end else begin
              mwrap[i] = (mq[i] == 0);
              mq[i] = (mq[i] + M - 1) % M;
            end
          end else begin
            mpre[i] = mpre[i] + 1;
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_all(input string ctx);
    logic [3:0] exp_tc;
    for (int i = 0; i < 2; i++) begin
      exp_tc = {3'b000, (up ? (mq[i] == M - 1) : (mq[i] == 0))};
      chk($sformatf("%s[%0d].q", ctx, i), (i == 0) ? q_a : q_b, 4'(mq[i]));
      chk($sformatf("%s[%0d].wrap", ctx, i), {3'b000, (i == 0) ? wrap_a : wrap_b},
          {3'b000, mwrap[i]});
      chk($sformatf("%s[%0d].tc", ctx, i), {3'b000, (i == 0) ? tc_a : tc_b}, exp_tc);
    end
  endtask

  task automatic step(input logic c, input logic l, input logic [3:0] lv,
                      input logic e, input logic u, input string ctx);
    clear = c; load = l; load_val = lv; en = e; up = u;
    #1 check_all(ctx);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; up = 1'b1; clear = 1'b0; load = 1'b0; load_val = '0;
    model_reset();
    #2 check_all("reset");
    @(negedge clk);
    reset = 1'b1;

    for (int k = 0; k < 24; k++) step(0, 0, 4'd0, 1, 1, "count_up");
    step(1, 0, 4'd0, 1, 1, "clear");
    for (int k = 0; k < 24; k++) step(0, 0, 4'd0, 1, 0, "count_down");

    for (int k = 0; k < 4; k++) step(0, 0, 4'd0, 1, 1, "pre_run");
    for (int k = 0; k < 5; k++) step(0, 0, 4'd0, 0, 1, "en_low");
    for (int k = 0; k < 6; k++) step(0, 0, 4'd0, 1, 1, "resume");

    step(0, 1, 4'd13, 1, 1, "load_sat");
    step(0, 1, 4'd7, 0, 0, "load_in");
    step(1, 1, 4'd5, 1, 1, "clear_wins");
    step(0, 0, 4'd0, 1, 1, "after_clear");

    step(1, 0, 4'd0, 0, 1, "pre_async");
    for (int k = 0; k < 6; k++) step(0, 0, 4'd0, 1, 1, "to_seven");
    @(posedge clk);
    model_edge();
    #2 chk("async_pre.q", q_a, 4'd7);
    reset = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 7; k++) step(0, 0, 4'd0, 1, 1, "post_rst");

    step(0, 1, 4'd5, 1, 1, "load5");
    step(0, 0, 4'd0, 1, 1, "dir_a");
    step(0, 0, 4'd0, 1, 0, "dir_flip");
    step(0, 0, 4'd0, 1, 0, "dir_b");
    step(0, 0, 4'd0, 1, 0, "dir_c");
    chk("dir_result.q", q_b, 4'd4);

    for (int k = 0; k < 400; k++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      step(r < 4, (r >= 4) && (r < 10), 4'($urandom_range(0, 15)),
           $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, "random");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
Name: mod_counter

Overview:
Parametrised modulo-N up/down counter with a built-in prescaler, synchronous clear and parallel load. It replaces the fixed 4-bit ripple counter on the DE1_SoC top level, where it drives LEDR/HEX displays. A single clk is used throughout, so there is no rippled clock domain. The prescaler lets the fast board clock produce a human-visible count rate without a separate divided clock.

Parameters:
WIDTH, 4, width of count output q; legal range 1..32.
MODULO, 16, count sequence is 0..MODULO-1; legal range 2..2^WIDTH.
PRESCALE, 1, enabled clk cycles per count step; legal range >=1 (1 = step every enabled cycle).

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
en  input  1  count enable; gates the prescaler and the counter.
up  input  1  direction: 1 = increment, 0 = decrement.
clear  input  1  synchronous clear of q and the prescaler.
load  input  1  synchronous parallel load.
load_val  input  WIDTH  value to load.
q  output  WIDTH  current count, registered.
tc  output  1  terminal count, combinational: up ? (q==MODULO-1) : (q==0).
wrap  output  1  registered one-cycle pulse; high in the cycle after q wrapped.

Behaviour:
- Reset (reset==0, asynchronous, immediate, any time including mid-count): q=0, internal prescaler pre=0, wrap=0. Release is sampled at the next clk edge.
- Internal prescaler pre: width max(1,clog2(PRESCALE)). tick = en && (pre==PRESCALE-1). For PRESCALE==1, tick = en.
- Per-edge priority (highest first): clear > load > tick > hold.
  - clear=1: q<=0, pre<=0, wrap<=0. Ignores en, load and up.
  - load=1 (clear=0): q<=min(load_val, MODULO-1), so out-of-range values saturate. pre<=0, wrap<=0.
  - en=1, no clear/load: pre<=(pre==PRESCALE-1) ? 0 : pre+1.
  - On tick, up=1: q<=(q==MODULO-1) ? 0 : q+1. wrap<=1 only when wrapping.
  - On tick, up=0: q<=(q==0) ? MODULO-1 : q-1. wrap<=1 only when wrapping.
  - en=0: q and pre hold, wrap<=0.
- wrap is high for exactly one cycle per wrap event. It is low in every other cycle, including consecutive non-wrapping ticks.
- up is sampled only on tick. Changing direction between ticks does not disturb pre or q.
- tc tracks the current up and q combinationally. It is valid during hold and is independent of en.
- Latency: a tick at edge k produces the new q and wrap visible after edge k. With en held high, q advances once every PRESCALE cycles.
- q never exceeds MODULO-1 under any input sequence.
- Arithmetic is modulo MODULO, not 2^WIDTH. When MODULO==2^WIDTH, behaviour equals natural binary wrap.

Test Plan:
1. WIDTH=4, MODULO=10, PRESCALE=1, up=1, en=1 from reset -> q steps 0,1,...,9,0. wrap high only in the cycle q returns to 0. tc high while q==9.
2. Same config, up=0 from q=0 -> q steps 9,8,...,0,9. wrap pulses on the 0->9 transition. tc high while q==0.
3. PRESCALE=3, en=1, up=1 -> q increments every 3rd cycle (0,0,0,1,1,1,2...). Dropping en for 5 cycles freezes q and pre, and counting resumes at the same phase.
4. load=1, load_val=4'd13 with MODULO=10 -> q=9 next cycle, wrap=0. Then clear=1 together with load=1, load_val=5 -> q=0 (clear wins).
5. Assert reset=0 asynchronously mid-cycle at q=7 -> q=0 and wrap=0 immediately, before the next clk edge. After release, counting restarts from 0 with a full PRESCALE interval.
6. up toggled 1->0 at q=5 between ticks (PRESCALE=3) -> next tick gives q=4. tc switches from (q==9) to (q==0) the same cycle up changes.
